// File: rtl/iterative_shift_ctrl.sv
// iterative_shift_ctrl: multi-cycle shift/rotate sequencer. It applies one
// single-bit shift or rotate step per clock to a latched operand and
// handshakes through start/busy/done.
module iterative_shift_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     result_d;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [2:0]           op_q;
    logic                 busy_q;
    logic                 done_q;

    // One-bit step of the working register; the op selects the fill bit
    always_comb begin
        result_d = result_q;
        case (op_q)
            OP_SLL:  result_d = {result_q[WIDTH-2:0], 1'b0};
            OP_SRL:  result_d = {1'b0, result_q[WIDTH-1:1]};
            OP_SRA:  result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            OP_ROL:  result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            OP_ROR:  result_d = {result_q[0], result_q[WIDTH-1:1]};
            default: result_d = result_q;
        endcase
    end

    // Sequencer FSM; busy/done are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        result_q <= a;
                        op_q     <= op;
                        cnt_q    <= shamt;
                        busy_q   <= 1'b1;
                        if ((shamt == '0) || (op >= OP_PASS)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            done_q  <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= result_d;
                    cnt_q    <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
